msi_snoop_cache_ctrl: RTL and testbench

//  Parametrised MSI snooping-coherence controller for a direct-mapped cache of 2**IDX_W lines.

---
 rtl/msi_snoop_cache_ctrl_pkg.sv | 36 +++
 rtl/msi_snoop_cache_ctrl_line_array.sv | 58 +++++
 rtl/msi_snoop_cache_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_msi_snoop_cache_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_snoop_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msi_pkg
// Description : Shared encodings for the MSI snooping cache controller:
//               line states, bus message codes and controller FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package msi_pkg;

  // Line coherence states (2'b11 is unused and behaves as Invalid)
  localparam logic [1:0] ST_INVALID = 2'b00;
  localparam logic [1:0] ST_EXCL    = 2'b01;
  localparam logic [1:0] ST_SHARED  = 2'b10;

  // Bus message codes
  localparam logic [2:0] MSG_EMPTY      = 3'b000;
  localparam logic [2:0] MSG_READ_MISS  = 3'b001;
  localparam logic [2:0] MSG_INVALIDATE = 3'b010;
  localparam logic [2:0] MSG_WRITE_MISS = 3'b011;
  localparam logic [2:0] MSG_WRITE_BACK = 3'b100;
  localparam logic [2:0] MSG_WB_CACHE   = 3'b101;

  // Controller FSM states
  typedef enum logic [1:0] {
    FSM_IDLE     = 2'b00,
    FSM_PROC_BUS = 2'b01,
    FSM_SNOOP_WB = 2'b10
  } fsm_t;

  // A line only counts as valid in Exclusive or Shared
  function automatic logic line_valid(input logic [1:0] st);
    return (st == ST_EXCL) || (st == ST_SHARED);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msi_snoop_cache_ctrl_line_array.sv
`default_nettype none
// ============================================================================
// Module      : msi_line_array
// Description : Per-line coherence state and tag storage. One synchronous
//               write port, three combinational read ports (proc/snoop/probe).
// Revision    : 1.0 - initial release
// ============================================================================
module msi_line_array
  import msi_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [1:0]              wstate,
  input  logic [ADDR_W-IDX_W-1:0] wtag,
  input  logic [IDX_W-1:0]        proc_idx,
  output logic [1:0]              proc_state,
  output logic [ADDR_W-IDX_W-1:0] proc_tag,
  input  logic [IDX_W-1:0]        snoop_idx,
  output logic [1:0]              snoop_state,
  output logic [ADDR_W-IDX_W-1:0] snoop_tag,
  input  logic [IDX_W-1:0]        probe_idx,
  output logic [1:0]              probe_state,
  output logic [ADDR_W-IDX_W-1:0] probe_tag
);

  localparam int NUM_LINES = 2 ** IDX_W;
  localparam int TAG_W     = ADDR_W - IDX_W;

  logic [1:0]       r_state [NUM_LINES];
  logic [TAG_W-1:0] r_tag   [NUM_LINES];

  // Line storage: cleared to Invalid/tag 0 on reset, single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_state[i] <= ST_INVALID;
        r_tag[i]   <= '0;
      end
    end else if (we) begin
      r_state[widx] <= wstate;
      r_tag[widx]   <= wtag;
    end
  end

  assign proc_state  = r_state[proc_idx];
  assign proc_tag    = r_tag[proc_idx];
  assign snoop_state = r_state[snoop_idx];
  assign snoop_tag   = r_tag[snoop_idx];
  assign probe_state = r_state[probe_idx];
  assign probe_tag   = r_tag[probe_idx];

endmodule
`default_nettype wire

// File: rtl/msi_snoop_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : msi_snoop_cache_ctrl
// Description : MSI snooping coherence controller for a direct-mapped cache.
//               Serves processor requests and snooped messages, emitting
//               coherence/write-back messages over a valid/ready bus.
// Revision    : 1.0 - initial release
// ============================================================================
module msi_snoop_cache_ctrl
  import msi_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    proc_valid,
  output logic                    proc_ready,
  input  logic                    proc_write,
  input  logic [ADDR_W-1:0]       proc_addr,
  output logic                    proc_done,
  output logic                    proc_hit,
  input  logic                    snoop_valid,
  output logic                    snoop_ready,
  input  logic [2:0]              snoop_msg,
  input  logic [ADDR_W-1:0]       snoop_addr,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic [2:0]              bus_msg,
  output logic [ADDR_W-1:0]       bus_addr,
  input  logic [IDX_W-1:0]        probe_idx,
  output logic [1:0]              probe_state,
  output logic [ADDR_W-IDX_W-1:0] probe_tag
);

  localparam int TAG_W = ADDR_W - IDX_W;

  // New line state after a processor access
  function automatic logic [1:0] proc_new_state(input logic [1:0] st, input logic hit,
                                                input logic wr);
    if (hit && st == ST_EXCL) return ST_EXCL;
    return wr ? ST_EXCL : ST_SHARED;
  endfunction

  // Processor message sequence {first, second}; MSG_EMPTY marks "none"
  function automatic logic [5:0] proc_msgs(input logic [1:0] st, input logic hit,
                                           input logic wr);
    if (!line_valid(st))  return {(wr ? MSG_WRITE_MISS : MSG_READ_MISS), MSG_EMPTY};
    if (st == ST_EXCL) begin
      if (hit)            return {MSG_EMPTY, MSG_EMPTY};
      return wr ? {MSG_WB_CACHE, MSG_WRITE_MISS} : {MSG_WRITE_BACK, MSG_READ_MISS};
    end
    if (hit)              return {(wr ? MSG_INVALIDATE : MSG_EMPTY), MSG_EMPTY};
    return {(wr ? MSG_WRITE_MISS : MSG_READ_MISS), MSG_EMPTY};
  endfunction

  // Snoop reaction on a hit: {new state, write-back required}
  function automatic logic [2:0] snoop_next(input logic [1:0] st, input logic [2:0] msg);
    case (msg)
      MSG_READ_MISS:  return (st == ST_EXCL) ? {ST_SHARED, 1'b1} : {st, 1'b0};
      MSG_WRITE_MISS: return {ST_INVALID, (st == ST_EXCL)};
      MSG_INVALIDATE: return {ST_INVALID, 1'b0};
      default:        return {st, 1'b0};
    endcase
  endfunction

  fsm_t              r_fsm, w_fsm_n;
  logic [2:0]        r_bus_msg, w_bus_msg_n, r_msg2, w_msg2_n;
  logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_n, r_addr2, w_addr2_n;
  logic [ADDR_W-1:0] r_req_addr, w_req_addr_n;
  logic [1:0]        r_req_state, w_req_state_n;
  logic              r_pend, w_pend_n, r_done, w_done_n, r_hit, w_hit_n;

  logic              w_we;
  logic [IDX_W-1:0]  w_widx;
  logic [1:0]        w_wstate;
  logic [TAG_W-1:0]  w_wtag;
  logic [1:0]        w_proc_st, w_snp_st;
  logic [TAG_W-1:0]  w_proc_ltag, w_snp_ltag;
  logic              w_proc_hit, w_snp_hit;
  logic [5:0]        w_msgs;
  logic [2:0]        w_snp_res;

  msi_line_array #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_lines (
    .clk         (clk),
    .rst         (rst),
    .we          (w_we),
    .widx        (w_widx),
    .wstate      (w_wstate),
    .wtag        (w_wtag),
    .proc_idx    (proc_addr[IDX_W-1:0]),
    .proc_state  (w_proc_st),
    .proc_tag    (w_proc_ltag),
    .snoop_idx   (snoop_addr[IDX_W-1:0]),
    .snoop_state (w_snp_st),
    .snoop_tag   (w_snp_ltag),
    .probe_idx   (probe_idx),
    .probe_state (probe_state),
    .probe_tag   (probe_tag)
  );

  assign w_proc_hit = line_valid(w_proc_st) && (w_proc_ltag == proc_addr[ADDR_W-1:IDX_W]);
  assign w_snp_hit  = line_valid(w_snp_st) && (w_snp_ltag == snoop_addr[ADDR_W-1:IDX_W]);
  assign w_msgs     = proc_msgs(w_proc_st, w_proc_hit, proc_write);
  assign w_snp_res  = snoop_next(w_snp_st, snoop_msg);

  assign proc_ready  = (r_fsm == FSM_IDLE) && !snoop_valid;
  assign snoop_ready = (r_fsm == FSM_IDLE);
  assign bus_valid   = (r_fsm != FSM_IDLE);
  assign bus_msg     = r_bus_msg;
  assign bus_addr    = r_bus_addr;
  assign proc_done   = r_done;
  assign proc_hit    = r_hit;

  // Controller state and held bus message; reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= FSM_IDLE;
      r_bus_msg   <= MSG_EMPTY;
      r_bus_addr  <= '0;
      r_msg2      <= MSG_EMPTY;
      r_addr2     <= '0;
      r_req_addr  <= '0;
      r_req_state <= ST_INVALID;
      r_pend      <= 1'b0;
      r_done      <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_n;
      r_bus_msg   <= w_bus_msg_n;
      r_bus_addr  <= w_bus_addr_n;
      r_msg2      <= w_msg2_n;
      r_addr2     <= w_addr2_n;
      r_req_addr  <= w_req_addr_n;
      r_req_state <= w_req_state_n;
      r_pend      <= w_pend_n;
      r_done      <= w_done_n;
      r_hit       <= w_hit_n;
    end
  end

  // Next-state, bus message sequencing and line-array write control
  always_comb begin
    w_fsm_n       = r_fsm;
    w_bus_msg_n   = r_bus_msg;
    w_bus_addr_n  = r_bus_addr;
    w_msg2_n      = r_msg2;
    w_addr2_n     = r_addr2;
    w_req_addr_n  = r_req_addr;
    w_req_state_n = r_req_state;
    w_pend_n      = r_pend;
    w_done_n      = 1'b0;
    w_hit_n       = 1'b0;
    w_we          = 1'b0;
    w_widx        = proc_addr[IDX_W-1:0];
    w_wstate      = ST_INVALID;
    w_wtag        = proc_addr[ADDR_W-1:IDX_W];
    case (r_fsm)
      FSM_IDLE: begin
        if (snoop_valid) begin
          // Snoops take priority; misses are accepted and dropped
          if (w_snp_hit) begin
            w_we     = 1'b1;
            w_widx   = snoop_addr[IDX_W-1:0];
            w_wtag   = snoop_addr[ADDR_W-1:IDX_W];
            w_wstate = w_snp_res[2:1];
            if (w_snp_res[0]) begin
              w_fsm_n      = FSM_SNOOP_WB;
              w_bus_msg_n  = MSG_WRITE_BACK;
              w_bus_addr_n = snoop_addr;
            end
          end
        end else if (proc_valid) begin
          if (w_msgs[5:3] == MSG_EMPTY) begin
            w_we     = 1'b1;
            w_wstate = proc_new_state(w_proc_st, w_proc_hit, proc_write);
            w_done_n = 1'b1;
            w_hit_n  = 1'b1;
          end else begin
            w_fsm_n       = FSM_PROC_BUS;
            w_bus_msg_n   = w_msgs[5:3];
            // Write-backs carry the victim line's address
            w_bus_addr_n  = (w_msgs[5:3] == MSG_WRITE_BACK || w_msgs[5:3] == MSG_WB_CACHE)
                            ? {w_proc_ltag, proc_addr[IDX_W-1:0]} : proc_addr;
            w_pend_n      = (w_msgs[2:0] != MSG_EMPTY);
            w_msg2_n      = w_msgs[2:0];
            w_addr2_n     = proc_addr;
            w_req_addr_n  = proc_addr;
            w_req_state_n = proc_new_state(w_proc_st, w_proc_hit, proc_write);
          end
        end
      end
      FSM_PROC_BUS: begin
        if (bus_ready) begin
          if (r_pend) begin
            w_bus_msg_n  = r_msg2;
            w_bus_addr_n = r_addr2;
            w_pend_n     = 1'b0;
          end else begin
            w_we     = 1'b1;
            w_widx   = r_req_addr[IDX_W-1:0];
            w_wtag   = r_req_addr[ADDR_W-1:IDX_W];
            w_wstate = r_req_state;
            w_done_n = 1'b1;
            w_fsm_n  = FSM_IDLE;
          end
        end
      end
      FSM_SNOOP_WB: begin
        if (bus_ready) w_fsm_n = FSM_IDLE;
      end
      default: w_fsm_n = FSM_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_msi_snoop_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_msi_snoop_cache_ctrl
// Description : Directed, table-driven bench for msi_snoop_cache_ctrl
//               (ADDR_W=8, IDX_W=2) with hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msi_snoop_cache_ctrl;

  localparam int ADDR_W = 8;
  localparam int IDX_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             proc_valid, proc_ready, proc_write, proc_done, proc_hit;
  logic [7:0]       proc_addr;
  logic             snoop_valid, snoop_ready;
  logic [2:0]       snoop_msg;
  logic [7:0]       snoop_addr;
  logic             bus_valid, bus_ready;
  logic [2:0]       bus_msg;
  logic [7:0]       bus_addr;
  logic [1:0]       probe_idx;
  logic [1:0]       probe_state;
  logic [5:0]       probe_tag;

  int n_cmp = 0;
  int n_bad = 0;

  msi_snoop_cache_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .proc_valid  (proc_valid),
    .proc_ready  (proc_ready),
    .proc_write  (proc_write),
    .proc_addr   (proc_addr),
    .proc_done   (proc_done),
    .proc_hit    (proc_hit),
    .snoop_valid (snoop_valid),
    .snoop_ready (snoop_ready),
    .snoop_msg   (snoop_msg),
    .snoop_addr  (snoop_addr),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_msg     (bus_msg),
    .bus_addr    (bus_addr),
    .probe_idx   (probe_idx),
    .probe_state (probe_state),
    .probe_tag   (probe_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    int         nmsg;
    logic [2:0] m0;
    logic [7:0] a0;
    logic [2:0] m1;
    logic [7:0] a1;
    logic       hit;
    logic [1:0] st;
    logic [5:0] tag;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic probe_check(input string name, input logic [1:0] idx,
                             input logic [1:0] st, input logic [5:0] tag);
    probe_idx = idx;
    #1;
    check({name, " state"}, {30'd0, probe_state}, {30'd0, st});
    check({name, " tag"},   {26'd0, probe_tag},   {26'd0, tag});
  endtask

  // Issue a processor request with bus_ready high, collect bus messages until proc_done
  task automatic run_proc(input logic wr, input logic [7:0] addr, output int n,
                          output logic [2:0] m0, output logic [7:0] a0,
                          output logic [2:0] m1, output logic [7:0] a1,
                          output logic hit, output logic done_seen);
    logic acc;
    n = 0; m0 = 3'd0; a0 = 8'd0; m1 = 3'd0; a1 = 8'd0; hit = 1'b0; done_seen = 1'b0;
    acc = 1'b0;
    proc_valid = 1'b1; proc_write = wr; proc_addr = addr; bus_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      acc = proc_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    proc_valid = 1'b0;
    if (!acc) check("accept timeout", 32'd0, 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (proc_done) begin
        done_seen = 1'b1;
        hit = proc_hit;
        break;
      end
      if (bus_valid) begin
        if (n == 0) begin m0 = bus_msg; a0 = bus_addr; end
        else if (n == 1) begin m1 = bus_msg; a1 = bus_addr; end
        n++;
      end
      @(posedge clk); #1;
    end
  endtask

  int         n;
  logic [2:0] m0, m1;
  logic [7:0] a0, a1;
  logic       hit, done_seen;

  initial begin
    //        wr    addr   n  m0    a0     m1    a1     hit   st     tag
    vecs[0]  = '{1'b0, 8'h05, 1, 3'd1, 8'h05, 3'd0, 8'h00, 1'b0, 2'b10, 6'h01};
    vecs[1]  = '{1'b1, 8'h05, 1, 3'd2, 8'h05, 3'd0, 8'h00, 1'b0, 2'b01, 6'h01};
    vecs[2]  = '{1'b1, 8'h05, 0, 3'd0, 8'h00, 3'd0, 8'h00, 1'b1, 2'b01, 6'h01};
    vecs[3]  = '{1'b0, 8'h05, 0, 3'd0, 8'h00, 3'd0, 8'h00, 1'b1, 2'b01, 6'h01};
    vecs[4]  = '{1'b1, 8'h0D, 2, 3'd5, 8'h05, 3'd3, 8'h0D, 1'b0, 2'b01, 6'h03};
    vecs[5]  = '{1'b0, 8'h02, 1, 3'd1, 8'h02, 3'd0, 8'h00, 1'b0, 2'b10, 6'h00};
    vecs[6]  = '{1'b0, 8'h02, 0, 3'd0, 8'h00, 3'd0, 8'h00, 1'b1, 2'b10, 6'h00};
    vecs[7]  = '{1'b0, 8'h06, 1, 3'd1, 8'h06, 3'd0, 8'h00, 1'b0, 2'b10, 6'h01};
    vecs[8]  = '{1'b1, 8'h0A, 1, 3'd3, 8'h0A, 3'd0, 8'h00, 1'b0, 2'b01, 6'h02};
    vecs[9]  = '{1'b1, 8'hFF, 1, 3'd3, 8'hFF, 3'd0, 8'h00, 1'b0, 2'b01, 6'h3F};
    vecs[10] = '{1'b0, 8'h03, 2, 3'd4, 8'hFF, 3'd1, 8'h03, 1'b0, 2'b10, 6'h00};

    rst = 1'b1; proc_valid = 1'b0; proc_write = 1'b0; proc_addr = 8'h00;
    snoop_valid = 1'b0; snoop_msg = 3'd0; snoop_addr = 8'h00; bus_ready = 1'b0;
    probe_idx = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    check("rst bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst proc_done", {31'd0, proc_done}, 32'd0);
    check("rst proc_hit",  {31'd0, proc_hit},  32'd0);
    check("rst bus_msg",   {29'd0, bus_msg},   32'd0);
    check("rst bus_addr",  {24'd0, bus_addr},  32'd0);
    check("rst proc_ready", {31'd0, proc_ready}, 32'd1);
    check("rst snoop_ready", {31'd0, snoop_ready}, 32'd1);
    for (int i = 0; i < 4; i++) probe_check($sformatf("rst line%0d", i), i[1:0], 2'b00, 6'h00);
    @(posedge clk); #1;

    // Table-driven processor accesses
    for (int i = 0; i < 11; i++) begin
      run_proc(vecs[i].wr, vecs[i].addr, n, m0, a0, m1, a1, hit, done_seen);
      check($sformatf("v%0d done", i), {31'd0, done_seen}, 32'd1);
      check($sformatf("v%0d nmsg", i), n, vecs[i].nmsg);
      check($sformatf("v%0d msg0", i), {29'd0, m0}, {29'd0, vecs[i].m0});
      check($sformatf("v%0d addr0", i), {24'd0, a0}, {24'd0, vecs[i].a0});
      check($sformatf("v%0d msg1", i), {29'd0, m1}, {29'd0, vecs[i].m1});
      check($sformatf("v%0d addr1", i), {24'd0, a1}, {24'd0, vecs[i].a1});
      check($sformatf("v%0d hit", i), {31'd0, hit}, {31'd0, vecs[i].hit});
      @(posedge clk); #1;
      check($sformatf("v%0d done pulse", i), {31'd0, proc_done}, 32'd0);
      probe_check($sformatf("v%0d line", i), vecs[i].addr[1:0], vecs[i].st, vecs[i].tag);
    end

    // Stalled eviction: line1 Exclusive tag 1, read 0x09 with bus_ready low 3 cycles
    run_proc(1'b1, 8'h05, n, m0, a0, m1, a1, hit, done_seen);
    check("stall setup done", {31'd0, done_seen}, 32'd1);
    @(posedge clk); #1;
    proc_valid = 1'b1; proc_write = 1'b0; proc_addr = 8'h09; bus_ready = 1'b0;
    @(posedge clk); #1;
    proc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d bus_valid", k), {31'd0, bus_valid}, 32'd1);
      check($sformatf("stall%0d bus_msg", k),   {29'd0, bus_msg},   32'd4);
      check($sformatf("stall%0d bus_addr", k),  {24'd0, bus_addr},  32'h05);
      if (k < 2) begin @(posedge clk); #1; end
    end
    bus_ready = 1'b1;
    @(posedge clk); #1;
    check("stall second valid", {31'd0, bus_valid}, 32'd1);
    check("stall second msg",   {29'd0, bus_msg},   32'd1);
    check("stall second addr",  {24'd0, bus_addr},  32'h09);
    @(posedge clk); #1;
    check("stall done", {31'd0, proc_done}, 32'd1);
    check("stall hit",  {31'd0, proc_hit},  32'd0);
    check("stall bus idle", {31'd0, bus_valid}, 32'd0);
    probe_check("stall line1", 2'd1, 2'b10, 6'h02);

    // Snoop ReadMiss on Exclusive line -> Shared with WriteBack, then WriteMiss -> Invalid
    run_proc(1'b1, 8'h05, n, m0, a0, m1, a1, hit, done_seen);
    check("snoop setup msg", {29'd0, m0}, 32'd3);
    @(posedge clk); #1;
    bus_ready = 1'b0;
    snoop_valid = 1'b1; snoop_msg = 3'd1; snoop_addr = 8'h05;
    #1;
    check("snoop rm snoop_ready", {31'd0, snoop_ready}, 32'd1);
    check("snoop rm proc_ready",  {31'd0, proc_ready},  32'd0);
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    check("snoop wb valid", {31'd0, bus_valid}, 32'd1);
    check("snoop wb msg",   {29'd0, bus_msg},   32'd4);
    check("snoop wb addr",  {24'd0, bus_addr},  32'h05);
    check("snoop wb snoop_ready", {31'd0, snoop_ready}, 32'd0);
    probe_check("snoop rm line1", 2'd1, 2'b10, 6'h01);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    check("snoop wb released", {31'd0, bus_valid}, 32'd0);
    check("snoop no done",     {31'd0, proc_done}, 32'd0);
    snoop_valid = 1'b1; snoop_msg = 3'd3; snoop_addr = 8'h05;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    check("snoop wm no msg", {31'd0, bus_valid}, 32'd0);
    probe_check("snoop wm line1", 2'd1, 2'b00, 6'h01);
    // Snoop miss on line3 (Shared tag 0) is ignored
    snoop_valid = 1'b1; snoop_msg = 3'd2; snoop_addr = 8'h07;
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    probe_check("snoop miss line3", 2'd3, 2'b10, 6'h00);

    // Same-cycle collision: snoop Invalidate wins, processor read follows
    run_proc(1'b0, 8'h05, n, m0, a0, m1, a1, hit, done_seen);
    check("coll setup msg", {29'd0, m0}, 32'd1);
    @(posedge clk); #1;
    proc_valid = 1'b1; proc_write = 1'b0; proc_addr = 8'h05;
    snoop_valid = 1'b1; snoop_msg = 3'd2; snoop_addr = 8'h05;
    #1;
    check("coll proc_ready",  {31'd0, proc_ready},  32'd0);
    check("coll snoop_ready", {31'd0, snoop_ready}, 32'd1);
    @(posedge clk); #1;
    snoop_valid = 1'b0;
    check("coll no done", {31'd0, proc_done}, 32'd0);
    check("coll no bus",  {31'd0, bus_valid}, 32'd0);
    probe_check("coll line1", 2'd1, 2'b00, 6'h01);
    run_proc(1'b0, 8'h05, n, m0, a0, m1, a1, hit, done_seen);
    check("coll proc done", {31'd0, done_seen}, 32'd1);
    check("coll proc nmsg", n, 1);
    check("coll proc msg",  {29'd0, m0}, 32'd1);
    check("coll proc hit",  {31'd0, hit}, 32'd0);
    @(posedge clk); #1;

    // Reset while a write-back waits on bus_ready
    proc_valid = 1'b1; proc_write = 1'b1; proc_addr = 8'h02; bus_ready = 1'b0;
    @(posedge clk); #1;
    proc_valid = 1'b0;
    check("rstmid valid", {31'd0, bus_valid}, 32'd1);
    check("rstmid msg",   {29'd0, bus_msg},   32'd5);
    check("rstmid addr",  {24'd0, bus_addr},  32'h0A);
    #2 rst = 1'b1;
    #1;
    check("rstmid bus drop", {31'd0, bus_valid}, 32'd0);
    for (int i = 0; i < 4; i++) probe_check($sformatf("rstmid line%0d", i), i[1:0], 2'b00, 6'h00);
    @(posedge clk); #1;
    rst = 1'b0; bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rstmid no done %0d", k), {31'd0, proc_done}, 32'd0);
      @(posedge clk); #1;
    end
    run_proc(1'b0, 8'h02, n, m0, a0, m1, a1, hit, done_seen);
    check("post rst msg",  {29'd0, m0}, 32'd1);
    check("post rst addr", {24'd0, a0}, 32'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
